// File: rtl/thermal_pkg.sv
// Shared thermal-path definitions: Peltier drive FSM encoding and default ramp/PWM settings.
package thermal_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RAMP_UP   = 3'd1,
      ST_HOLD      = 3'd2,
      ST_RAMP_DOWN = 3'd3,
      ST_FAULT     = 3'd4
   } state_t;

   localparam int         PWM_BITS_DEF  = 8;
   localparam logic [7:0] DUTY_MAX_DEF  = 8'd240;
   localparam logic [7:0] RAMP_STEP_DEF = 8'd16;

endpackage

// File: rtl/peltier_drive_ctrl_pwm_gen.sv
// Free-running PWM counter with registered compare; pwm follows duty one cycle later.
// i_kill forces the output low on the same edge, used when the power stage must be cut.
module pwm_gen #(
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_kill,
   input  logic [PWM_BITS-1:0] i_duty,
   output logic                o_pwm
);

   logic [PWM_BITS-1:0] r_cnt;
   logic                r_pwm;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_pwm <= 1'b0;
      end else begin
         r_cnt <= r_cnt + PWM_BITS'(1);
         r_pwm <= !i_kill && (r_cnt < i_duty);
      end
   end

   assign o_pwm = r_pwm;

endmodule

// File: rtl/peltier_drive_ctrl.sv
// Peltier H-bridge drive: soft-start/stop duty ramp, minimum off time, latched fault.
// Inputs act one edge after sampling; pwm_out lags duty by one cycle except on fault entry.
module peltier_drive_ctrl
   import thermal_pkg::*;
#(
   parameter int                  PWM_BITS  = PWM_BITS_DEF,
   parameter logic [PWM_BITS-1:0] DUTY_MAX  = DUTY_MAX_DEF,
   parameter logic [PWM_BITS-1:0] RAMP_STEP = RAMP_STEP_DEF,
   parameter logic [15:0]         RAMP_DIV  = 16'd1000,
   parameter logic [15:0]         MIN_OFF   = 16'd50000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                peltier_enable,
   input  logic                critical_shutdown,
   input  logic                fault_clear,
   output logic                pwm_out,
   output logic [PWM_BITS-1:0] duty,
   output logic                power_cut,
   output logic [2:0]          state
);

   state_t              r_state;
   logic [PWM_BITS-1:0] r_duty;
   logic                r_power_cut;
   logic [15:0]         r_presc;
   logic [15:0]         r_minoff;

   state_t              w_state_nxt;
   logic [PWM_BITS-1:0] w_duty_nxt;
   logic                w_reload;
   logic                w_tick;
   logic [PWM_BITS:0]   w_up_sum;
   logic [PWM_BITS-1:0] w_up_duty;
   logic [PWM_BITS-1:0] w_dn_duty;

   assign w_tick    = (r_presc == RAMP_DIV - 16'd1);
   // One extra bit so duty+step near the top of the range cannot wrap before clamping.
   assign w_up_sum  = {1'b0, r_duty} + {1'b0, RAMP_STEP};
   assign w_up_duty = (w_up_sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : w_up_sum[PWM_BITS-1:0];
   assign w_dn_duty = (r_duty > RAMP_STEP) ? (r_duty - RAMP_STEP) : '0;

   always_comb begin
      w_state_nxt = r_state;
      w_duty_nxt  = r_duty;
      w_reload    = 1'b0;
      if (critical_shutdown) begin
         w_state_nxt = ST_FAULT;
         w_duty_nxt  = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_duty_nxt = '0;
               if (peltier_enable && (r_minoff == 16'd0)) w_state_nxt = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
               if (!peltier_enable) begin
                  w_state_nxt = ST_RAMP_DOWN;
               end else if (w_tick) begin
                  w_duty_nxt = w_up_duty;
                  if (w_up_duty == DUTY_MAX) w_state_nxt = ST_HOLD;
               end
            end
            ST_HOLD: begin
               w_duty_nxt = DUTY_MAX;
               if (!peltier_enable) w_state_nxt = ST_RAMP_DOWN;
            end
            ST_RAMP_DOWN: begin
               // Reversal skips the min-off wait: duty never reached zero.
               if (peltier_enable) begin
                  w_state_nxt = ST_RAMP_UP;
               end else if (w_tick) begin
                  w_duty_nxt = w_dn_duty;
                  if (w_dn_duty == '0) begin
                     w_state_nxt = ST_IDLE;
                     w_reload    = 1'b1;
                  end
               end
            end
            ST_FAULT: begin
               w_duty_nxt = '0;
               if (fault_clear) begin
                  w_state_nxt = ST_IDLE;
                  w_reload    = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_duty_nxt  = '0;
               w_reload    = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_duty      <= '0;
         r_power_cut <= 1'b0;
         r_presc     <= '0;
         r_minoff    <= MIN_OFF;
      end else begin
         r_state     <= w_state_nxt;
         r_duty      <= w_duty_nxt;
         r_power_cut <= (w_state_nxt == ST_FAULT);
         if ((w_state_nxt != r_state) || w_tick) r_presc <= '0;
         else                                    r_presc <= r_presc + 16'd1;
         if (w_reload)                                        r_minoff <= MIN_OFF;
         else if ((r_state == ST_IDLE) && (r_minoff != 16'd0)) r_minoff <= r_minoff - 16'd1;
      end
   end

   pwm_gen #(
      .PWM_BITS (PWM_BITS)
   ) u_pwm (
      .clk    (clk),
      .rst    (rst),
      .i_kill (w_state_nxt == ST_FAULT),
      .i_duty (r_duty),
      .o_pwm  (pwm_out)
   );

   assign duty      = r_duty;
   assign power_cut = r_power_cut;
   assign state     = r_state;

endmodule

// File: tb/tb_peltier_drive_ctrl.sv
// Directed bench for peltier_drive_ctrl with RAMP_DIV=4 and MIN_OFF=10.
module tb_peltier_drive_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       peltier_enable = 1'b0;
   logic       critical_shutdown = 1'b0;
   logic       fault_clear = 1'b0;
   logic       pwm_out;
   logic [7:0] duty;
   logic       power_cut;
   logic [2:0] state;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [2:0] S_IDLE = 3'd0, S_UP = 3'd1, S_HOLD = 3'd2, S_DOWN = 3'd3, S_FAULT = 3'd4;

   peltier_drive_ctrl #(
      .PWM_BITS  (8),
      .DUTY_MAX  (8'd240),
      .RAMP_STEP (8'd16),
      .RAMP_DIV  (16'd4),
      .MIN_OFF   (16'd10)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .peltier_enable    (peltier_enable),
      .critical_shutdown (critical_shutdown),
      .fault_clear       (fault_clear),
      .pwm_out           (pwm_out),
      .duty              (duty),
      .power_cut         (power_cut),
      .state             (state)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      n_checks++; if (state !== S_IDLE) $display("FAIL reset_state got %0d want %0d", state, S_IDLE); else n_pass++;
      n_checks++; if (duty !== 8'd0) $display("FAIL reset_duty got %0d want 0", duty); else n_pass++;
      n_checks++; if (pwm_out !== 1'b0) $display("FAIL reset_pwm got %b want 0", pwm_out); else n_pass++;
      n_checks++; if (power_cut !== 1'b0) $display("FAIL reset_power_cut got %b want 0", power_cut); else n_pass++;
   endtask

   // Enable raised right after reset: timer 10 counts down, RAMP_UP on the 11th edge.
   task automatic test_ramp_up();
      int cnt;
      int hi;
      cnt = 0;
      peltier_enable = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (state == S_UP) break;
         step(1);
         cnt++;
      end
      n_checks++; if (cnt !== 11) $display("FAIL minoff_after_reset got %0d cycles want 11", cnt); else n_pass++;
      n_checks++; if (duty !== 8'd0) $display("FAIL rampup_entry_duty got %0d want 0", duty); else n_pass++;
      for (int k = 1; k <= 15; k++) begin
         step(4);
         n_checks++;
         if (duty !== 8'(16 * k)) $display("FAIL rampup_duty tick %0d got %0d want %0d", k, duty, 16 * k);
         else n_pass++;
      end
      n_checks++; if (state !== S_HOLD) $display("FAIL rampup_hold got %0d want %0d", state, S_HOLD); else n_pass++;
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         step(1);
         if (pwm_out === 1'b1) hi++;
      end
      n_checks++; if (hi !== 240) $display("FAIL pwm_high_count got %0d want 240", hi); else n_pass++;
      n_checks++; if (state !== S_HOLD) $display("FAIL hold_stays got %0d want %0d", state, S_HOLD); else n_pass++;
   endtask

   task automatic test_ramp_down();
      int cnt;
      peltier_enable = 1'b0;
      step(1);
      n_checks++; if (state !== S_DOWN) $display("FAIL rampdown_entry got %0d want %0d", state, S_DOWN); else n_pass++;
      n_checks++; if (duty !== 8'd240) $display("FAIL rampdown_entry_duty got %0d want 240", duty); else n_pass++;
      for (int k = 1; k <= 15; k++) begin
         step(4);
         n_checks++;
         if (duty !== 8'(240 - 16 * k)) $display("FAIL rampdown_duty tick %0d got %0d want %0d", k, duty, 240 - 16 * k);
         else n_pass++;
      end
      n_checks++; if (state !== S_IDLE) $display("FAIL rampdown_idle got %0d want %0d", state, S_IDLE); else n_pass++;
      peltier_enable = 1'b1;
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (state == S_IDLE) cnt++;
         else break;
      end
      n_checks++; if (cnt !== 10) $display("FAIL minoff_idle_cycles got %0d want 10", cnt); else n_pass++;
      n_checks++; if (state !== S_UP) $display("FAIL minoff_then_rampup got %0d want %0d", state, S_UP); else n_pass++;
   endtask

   task automatic test_reverse();
      step(20);
      n_checks++; if (duty !== 8'd80) $display("FAIL reverse_reach80 got %0d want 80", duty); else n_pass++;
      peltier_enable = 1'b0;
      step(1);
      n_checks++; if (state !== S_DOWN || duty !== 8'd80) $display("FAIL reverse_down state %0d duty %0d want %0d duty 80", state, duty, S_DOWN); else n_pass++;
      step(4);
      n_checks++; if (duty !== 8'd64) $display("FAIL reverse_down64 got %0d want 64", duty); else n_pass++;
      step(4);
      n_checks++; if (duty !== 8'd48) $display("FAIL reverse_down48 got %0d want 48", duty); else n_pass++;
      peltier_enable = 1'b1;
      step(1);
      n_checks++; if (state !== S_UP || duty !== 8'd48) $display("FAIL reverse_up state %0d duty %0d want %0d duty 48", state, duty, S_UP); else n_pass++;
      step(4);
      n_checks++; if (state !== S_UP || duty !== 8'd64) $display("FAIL reverse_next state %0d duty %0d want %0d duty 64", state, duty, S_UP); else n_pass++;
   endtask

   task automatic test_fault();
      step(44);
      n_checks++; if (state !== S_HOLD) $display("FAIL fault_pre_hold got %0d want %0d", state, S_HOLD); else n_pass++;
      critical_shutdown = 1'b1;
      step(1);
      n_checks++; if (state !== S_FAULT) $display("FAIL fault_state got %0d want %0d", state, S_FAULT); else n_pass++;
      n_checks++; if (duty !== 8'd0) $display("FAIL fault_duty got %0d want 0", duty); else n_pass++;
      n_checks++; if (pwm_out !== 1'b0) $display("FAIL fault_pwm got %b want 0", pwm_out); else n_pass++;
      n_checks++; if (power_cut !== 1'b1) $display("FAIL fault_power_cut got %b want 1", power_cut); else n_pass++;
      fault_clear = 1'b1;
      step(1);
      fault_clear = 1'b0;
      n_checks++; if (state !== S_FAULT || power_cut !== 1'b1) $display("FAIL clear_while_critical state %0d cut %b want %0d cut 1", state, power_cut, S_FAULT); else n_pass++;
      critical_shutdown = 1'b0;
      step(3);
      n_checks++; if (state !== S_FAULT) $display("FAIL fault_latched got %0d want %0d", state, S_FAULT); else n_pass++;
      fault_clear = 1'b1;
      step(1);
      fault_clear = 1'b0;
      n_checks++; if (state !== S_IDLE || power_cut !== 1'b0) $display("FAIL fault_exit state %0d cut %b want %0d cut 0", state, power_cut, S_IDLE); else n_pass++;
   endtask

   // Enable stays high throughout; ramp must wait for clear plus the full min-off time.
   task automatic test_fault_enable();
      int cnt;
      peltier_enable = 1'b1;
      step(2);
      critical_shutdown = 1'b1;
      step(1);
      n_checks++; if (state !== S_FAULT) $display("FAIL fe_enter got %0d want %0d", state, S_FAULT); else n_pass++;
      critical_shutdown = 1'b1;
      fault_clear = 1'b1;
      step(1);
      fault_clear = 1'b0;
      n_checks++; if (state !== S_FAULT) $display("FAIL fe_both_high got %0d want %0d", state, S_FAULT); else n_pass++;
      critical_shutdown = 1'b0;
      step(5);
      n_checks++; if (state !== S_FAULT || duty !== 8'd0) $display("FAIL fe_no_ramp state %0d duty %0d want %0d duty 0", state, duty, S_FAULT); else n_pass++;
      fault_clear = 1'b1;
      step(1);
      fault_clear = 1'b0;
      n_checks++; if (state !== S_IDLE) $display("FAIL fe_cleared got %0d want %0d", state, S_IDLE); else n_pass++;
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (state == S_IDLE) cnt++;
         else break;
      end
      n_checks++; if (cnt !== 10 || state !== S_UP) $display("FAIL fe_minoff idle %0d state %0d want idle 10 state %0d", cnt, state, S_UP); else n_pass++;
   endtask

   task automatic test_reset_midramp();
      step(32);
      n_checks++; if (state !== S_UP || duty !== 8'd128) $display("FAIL mid_pre state %0d duty %0d want %0d duty 128", state, duty, S_UP); else n_pass++;
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      n_checks++; if (duty !== 8'd0) $display("FAIL mid_rst_duty got %0d want 0", duty); else n_pass++;
      n_checks++; if (state !== S_IDLE) $display("FAIL mid_rst_state got %0d want %0d", state, S_IDLE); else n_pass++;
      n_checks++; if (pwm_out !== 1'b0 || power_cut !== 1'b0) $display("FAIL mid_rst_outs pwm %b cut %b want 0 0", pwm_out, power_cut); else n_pass++;
   endtask

   initial begin
      step(1);
      test_reset();
      test_ramp_up();
      test_ramp_down();
      test_reverse();
      test_fault();
      test_fault_enable();
      test_reset_midramp();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/peltier_drive_ctrl.md
# peltier_drive_ctrl

Downstream consumer of the thermal manager's `peltier_enable` and `critical_shutdown` flags. It converts the on/off cooling request into a PWM drive for the Peltier H-bridge, with a soft-start/soft-stop duty ramp and a minimum off time. It latches critical-shutdown events into a fault state that only an explicit clear can exit. It sits between the thermal manager and the power-stage gate driver.

## Interface
- `PWM_BITS`, 8: PWM counter and duty width.
- `DUTY_MAX`, 8'd240: duty ceiling reached by the ramp; must be ≤ 2^PWM_BITS−1.
- `RAMP_STEP`, 8'd16: duty increment/decrement per ramp tick.
- `RAMP_DIV`, 16'd1000: clock cycles per ramp tick; must be ≥ 1.
- `MIN_OFF`, 16'd50000: clock cycles duty must stay 0 in IDLE before a new ramp-up.
- `clk` in 1: single clock. Reset is synchronous and active-high.
- `rst` in 1: synchronous active-high reset.
- `peltier_enable` in 1: cooling request, level.
- `critical_shutdown` in 1: critical over-temperature, level.
- `fault_clear` in 1: single-cycle pulse that re-arms after a fault.
- `pwm_out` out 1: gate drive, registered.
- `duty` out PWM_BITS: current duty value.
- `power_cut` out 1: high while in FAULT, registered.
- `state` out 3: current FSM state encoding.

## Operation
- States:
  - IDLE=0
  - RAMP_UP=1
  - HOLD=2
  - RAMP_DOWN=3
  - FAULT=4
- Reset values:
  - state=IDLE, duty=0, pwm_out=0, power_cut=0.
  - PWM counter 0, prescaler 0.
  - Min-off timer loaded with MIN_OFF, so a ramp-up is not allowed immediately after reset.
- Priority, evaluated every cycle: `rst` > `critical_shutdown` > `fault_clear` > `peltier_enable`.
- Any state with `critical_shutdown`=1 → FAULT. On that transition, duty is forced to 0 and power_cut is set to 1.
- FAULT → IDLE only when `fault_clear`=1 and `critical_shutdown`=0 in the same cycle. Otherwise the block stays in FAULT, regardless of `peltier_enable`. On exit, power_cut drops to 0 and the min-off timer reloads.
- IDLE:
  - Min-off timer decrements to 0 and saturates there.
  - When the timer is 0 and `peltier_enable`=1 → RAMP_UP.
- RAMP_UP:
  - Each ramp tick: duty = min(duty+RAMP_STEP, DUTY_MAX), computed at PWM_BITS+1 width to avoid wrap.
  - When duty reaches DUTY_MAX → HOLD.
  - `peltier_enable`=0 → RAMP_DOWN, keeping the current duty.
- HOLD: duty stays at DUTY_MAX. `peltier_enable`=0 → RAMP_DOWN.
- RAMP_DOWN:
  - Each tick: duty = max(duty−RAMP_STEP, 0), saturating and never wrapping.
  - When duty reaches 0 → IDLE, with the min-off timer reloaded to MIN_OFF.
  - `peltier_enable`=1 → RAMP_UP from the current duty. The min-off timer does not apply because duty never reached 0.
- Prescaler:
  - Counts 0..RAMP_DIV−1; a tick occurs when it wraps.
  - Clears on every state transition, so the first tick in a new state comes RAMP_DIV cycles after entry.
- PWM:
  - Free-running PWM_BITS counter, wraps at 2^PWM_BITS−1 → 0.
  - pwm_out registered as (counter < duty). duty=0 gives constant low.
- `fault_clear` outside FAULT is ignored.

## Timing
- `critical_shutdown` sampled high at edge N → state=FAULT, duty=0, power_cut=1, pwm_out=0 all visible after edge N.
- `pwm_out` reflects a duty change one cycle after `duty` updates.
- Ramp 0→DUTY_MAX takes ceil(DUTY_MAX/RAMP_STEP) ticks. With defaults: 15 ticks = 15000 cycles after entering RAMP_UP.
- Enable edges act one cycle after sampling. There is no input synchronizer; inputs come from the same clock domain.
- `rst` asserted mid-ramp or in FAULT → all outputs return to reset values at the next edge.

## Structure
- Shared package `thermal_pkg`: state enum encoding (IDLE..FAULT, 3 bits), default PWM_BITS, DUTY_MAX, RAMP_STEP.
- One sub-module, `pwm_gen` (PWM counter plus registered compare), parameterised by PWM_BITS. The FSM, prescaler, min-off timer and duty register live in the top module.

## Test plan
- Reset, wait MIN_OFF, raise enable (RAMP_DIV=4, MIN_OFF=10 in bench) → duty 16,32,…,240 every 4 cycles, state HOLD after 15 ticks, pwm_out high 240/256 cycles per PWM period.
- In HOLD, drop enable → duty decreases by 16 per tick to 0, state IDLE. Re-raise enable immediately → stays IDLE exactly 10 cycles, then RAMP_UP.
- Drop enable at duty=80, then re-raise at duty=48 → RAMP_DOWN→RAMP_UP with no IDLE visit, next duty 64.
- Assert critical_shutdown in HOLD → next cycle state=FAULT, duty=0, pwm_out=0, power_cut=1. Pulse fault_clear while critical still high → remains FAULT. Drop critical, then pulse fault_clear → IDLE, power_cut=0.
- critical_shutdown and fault_clear both high in the same cycle while in FAULT → stays FAULT. Enable held high throughout → no ramp until cleared and MIN_OFF elapsed.
- Assert rst at duty=128 in RAMP_UP → next cycle duty=0, state=IDLE, pwm_out=0, power_cut=0.
